// File: rtl/mux_nx1_pipe_if.sv
// Bus bundle for mux_nx1_pipe: N_IN producer channels in, one selected beat out,
// each side with its own valid/ready handshake.
interface mux_nx1_pipe_if #(
  parameter int WIDTH = 4,
  parameter int N_IN  = 4
);
  localparam int LOG2N = $clog2(N_IN);

  logic [N_IN*WIDTH-1:0] in_data;
  logic [LOG2N-1:0]      sel;
  logic                  rr_mode;
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      out_data;
  logic [LOG2N-1:0]      out_sel;
  logic                  out_valid;
  logic                  out_ready;

  modport slave (
    input  in_data, sel, rr_mode, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );

  modport master (
    output in_data, sel, rr_mode, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/mux_nx1_pipe.sv
// Pipelined N:1 multiplexer: a registered tree of 2:1 selections, one register
// stage per tree level, with a global stall and an optional round-robin select.
module mux_nx1_pipe #(
  parameter int WIDTH = 4,
  parameter int N_IN  = 4
) (
  input logic           clk,
  input logic           rst_n,
  mux_nx1_pipe_if.slave bus
);
  localparam int LOG2N  = $clog2(N_IN);
  localparam int TREE_N = 2*N_IN - 1;

  // Stage k's entries live at this entry offset in the flattened tree; stage 0 is in_data.
  function automatic int stage_off(input int k);
    return 2*N_IN - 2*(N_IN >> k);
  endfunction

  logic                    adv;
  logic                    accept;
  logic [LOG2N-1:0]        rr_ptr;
  logic [LOG2N-1:0]        esel;
  logic [TREE_N*WIDTH-1:0] stage_data;
  logic [LOG2N-1:0]        stage_sel [0:LOG2N];
  logic [LOG2N:0]          stage_valid;

  assign adv          = !stage_valid[LOG2N] || bus.out_ready;
  assign accept       = bus.in_valid && adv;
  assign esel         = bus.rr_mode ? rr_ptr : bus.sel;
  assign bus.in_ready = adv;

  assign stage_data[N_IN*WIDTH-1:0] = bus.in_data;
  assign stage_sel[0]               = esel;
  assign stage_valid[0]             = bus.in_valid;

  // Pointer only moves on beats that actually enter the pipe in round-robin mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept && bus.rr_mode) begin
      rr_ptr <= rr_ptr + 1'b1;
    end
  end

  for (genvar k = 1; k <= LOG2N; k++) begin : g_stage
    localparam int NE = N_IN >> k;
    localparam int PO = stage_off(k-1);
    localparam int CO = stage_off(k);

    logic [NE*WIDTH-1:0] data_q;
    logic [LOG2N-1:0]    sel_q;
    logic                valid_q;

    // Valid bits always follow on advance; payload only loads behind a valid beat
    // so out_data keeps the last real beat across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q  <= '0;
        sel_q   <= '0;
        valid_q <= 1'b0;
      end else if (adv) begin
        valid_q <= stage_valid[k-1];
        if (stage_valid[k-1]) begin
          sel_q <= stage_sel[k-1];
          for (int j = 0; j < NE; j++) begin
            data_q[j*WIDTH +: WIDTH] <= stage_sel[k-1][k-1]
                                        ? stage_data[(PO+2*j+1)*WIDTH +: WIDTH]
                                        : stage_data[(PO+2*j)*WIDTH +: WIDTH];
          end
        end
      end
    end

    assign stage_data[CO*WIDTH +: NE*WIDTH] = data_q;
    assign stage_sel[k]                     = sel_q;
    assign stage_valid[k]                   = valid_q;
  end

  assign bus.out_data  = stage_data[(TREE_N-1)*WIDTH +: WIDTH];
  assign bus.out_sel   = stage_sel[LOG2N];
  assign bus.out_valid = stage_valid[LOG2N];
endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Bench for mux_nx1_pipe: cycle vector table, hand-written corner sequences and a
// randomized run checked by a queue scoreboard that tracks accepted beats.
module tb_mux_nx1_pipe;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mux_nx1_pipe_if #(.WIDTH(4), .N_IN(4)) ifc4();
  mux_nx1_pipe_if #(.WIDTH(8), .N_IN(8)) ifc8();

  mux_nx1_pipe #(.WIDTH(4), .N_IN(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(ifc4.slave));
  mux_nx1_pipe #(.WIDTH(8), .N_IN(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(ifc8.slave));

  typedef struct {
    logic       vld;
    logic [1:0] sel;
    logic       rr;
    logic       ordy;
    logic       e_vld;
    logic [3:0] e_data;
    logic [1:0] e_sel;
    logic       e_irdy;
  } vec_t;

  vec_t       vecs[$];
  int         checks = 0;
  int         errors = 0;
  logic [5:0] sb_q[$];
  int         model_ptr = 0;
  logic       prev_stall = 1'b0;
  logic [3:0] prev_data = '0;
  logic [1:0] prev_sel = '0;

  function automatic vec_t mk(input int vld, input int sel, input int rr, input int ordy,
                              input int e_vld, input int e_data, input int e_sel, input int e_irdy);
    vec_t v;
    v.vld    = 1'(vld);
    v.sel    = 2'(sel);
    v.rr     = 1'(rr);
    v.ordy   = 1'(ordy);
    v.e_vld  = 1'(e_vld);
    v.e_data = 4'(e_data);
    v.e_sel  = 2'(e_sel);
    v.e_irdy = 1'(e_irdy);
    return v;
  endfunction

  task automatic checkVal(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    ifc4.in_valid  = v.vld;
    ifc4.sel       = v.sel;
    ifc4.rr_mode   = v.rr;
    ifc4.out_ready = v.ordy;
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    @(negedge clk);
    checkVal({tag, "_out_valid"}, int'(ifc4.out_valid), int'(v.e_vld));
    checkVal({tag, "_out_data"},  int'(ifc4.out_data),  int'(v.e_data));
    checkVal({tag, "_out_sel"},   int'(ifc4.out_sel),   int'(v.e_sel));
    checkVal({tag, "_in_ready"},  int'(ifc4.in_ready),  int'(v.e_irdy));
  endtask

  task automatic step8(input int vld, input int sel, input int e_vld, input int e_data, input int e_sel);
    @(posedge clk);
    #1;
    ifc8.in_valid = 1'(vld);
    ifc8.sel      = 3'(sel);
    @(negedge clk);
    checkVal("n8_out_valid", int'(ifc8.out_valid), e_vld);
    checkVal("n8_out_data",  int'(ifc8.out_data),  e_data);
    checkVal("n8_out_sel",   int'(ifc8.out_sel),   e_sel);
  endtask

  // Scoreboard: every accepted beat is queued with the channel its select picks;
  // every popped output beat must match the oldest queued one.
  always @(negedge clk) begin
    logic [1:0] es;
    logic [5:0] exp_beat;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      checkVal("in_ready_rule", int'(ifc4.in_ready), int'(!ifc4.out_valid || ifc4.out_ready));
      if (prev_stall) begin
        checkVal("stall_out_valid", int'(ifc4.out_valid), 1);
        checkVal("stall_out_data",  int'(ifc4.out_data),  int'(prev_data));
        checkVal("stall_out_sel",   int'(ifc4.out_sel),   int'(prev_sel));
      end
      if (ifc4.out_valid && ifc4.out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb_extra_beat: got data %0h sel %0h expected no beat", ifc4.out_data, ifc4.out_sel);
        end else begin
          exp_beat = sb_q.pop_front();
          checkVal("sb_out_data", int'(ifc4.out_data), int'(exp_beat[3:0]));
          checkVal("sb_out_sel",  int'(ifc4.out_sel),  int'(exp_beat[5:4]));
        end
      end
      if (ifc4.in_valid && ifc4.in_ready) begin
        es = ifc4.rr_mode ? 2'(model_ptr) : ifc4.sel;
        sb_q.push_back({es, ifc4.in_data[int'(es)*4 +: 4]});
        if (ifc4.rr_mode) model_ptr = (model_ptr + 1) % 4;
      end
      prev_stall = ifc4.out_valid && !ifc4.out_ready;
      prev_data  = ifc4.out_data;
      prev_sel   = ifc4.out_sel;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t idle;

    // Static select, channels a=0 b=3 c=4 d=6.
    vecs.push_back(mk(1,0,0,1, 0,0,0,1));
    vecs.push_back(mk(1,1,0,1, 0,0,0,1));
    vecs.push_back(mk(1,2,0,1, 1,0,0,1));
    vecs.push_back(mk(1,3,0,1, 1,3,1,1));
    vecs.push_back(mk(0,0,0,1, 1,4,2,1));
    vecs.push_back(mk(0,0,0,1, 1,6,3,1));
    vecs.push_back(mk(0,0,0,1, 0,6,3,1));
    // Round-robin with sel=3 ignored, six beats wrapping 3->0.
    vecs.push_back(mk(1,3,1,1, 0,6,3,1));
    vecs.push_back(mk(1,3,1,1, 0,6,3,1));
    vecs.push_back(mk(1,3,1,1, 1,0,0,1));
    vecs.push_back(mk(1,3,1,1, 1,3,1,1));
    vecs.push_back(mk(1,3,1,1, 1,4,2,1));
    vecs.push_back(mk(1,3,1,1, 1,6,3,1));
    vecs.push_back(mk(0,3,1,1, 1,0,0,1));
    vecs.push_back(mk(0,3,1,1, 1,3,1,1));
    vecs.push_back(mk(0,3,1,1, 0,3,1,1));
    // Backpressure: three-cycle stall once the first beat reaches the output.
    vecs.push_back(mk(1,1,0,1, 0,3,1,1));
    vecs.push_back(mk(1,2,0,1, 0,3,1,1));
    vecs.push_back(mk(1,3,0,0, 1,3,1,0));
    vecs.push_back(mk(1,3,0,0, 1,3,1,0));
    vecs.push_back(mk(1,3,0,0, 1,3,1,0));
    vecs.push_back(mk(1,3,0,1, 1,3,1,1));
    vecs.push_back(mk(0,0,0,1, 1,4,2,1));
    vecs.push_back(mk(0,0,0,1, 1,6,3,1));
    vecs.push_back(mk(0,0,0,1, 0,6,3,1));

    rst_n          = 1'b0;
    ifc4.in_data   = {4'd6, 4'd4, 4'd3, 4'd0};
    ifc4.sel       = '0;
    ifc4.rr_mode   = 1'b0;
    ifc4.in_valid  = 1'b0;
    ifc4.out_ready = 1'b1;
    ifc8.sel       = '0;
    ifc8.rr_mode   = 1'b0;
    ifc8.in_valid  = 1'b0;
    ifc8.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) ifc8.in_data[i*8 +: 8] = 8'h10 + 8'(i);

    repeat (2) @(posedge clk);
    idle = mk(0,0,0,1, 0,0,0,1);
    checkOutput(idle, "reset");
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], $sformatf("vec%0d", i));
    end

    // Two round-robin beats in flight (pointer at 2), then asynchronous reset mid-cycle.
    applyStimulus(mk(1,0,1,1, 0,6,3,1));
    checkOutput(mk(1,0,1,1, 0,6,3,1), "rst_pre0");
    applyStimulus(mk(1,0,1,1, 0,6,3,1));
    checkOutput(mk(1,0,1,1, 0,6,3,1), "rst_pre1");
    applyStimulus(mk(0,0,1,1, 1,4,2,1));
    checkOutput(mk(0,0,1,1, 1,4,2,1), "rst_pre2");
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("async_rst_out_valid", int'(ifc4.out_valid), 0);
    checkVal("async_rst_out_data",  int'(ifc4.out_data),  0);
    checkVal("async_rst_out_sel",   int'(ifc4.out_sel),   0);
    checkVal("async_rst_in_ready",  int'(ifc4.in_ready),  1);
    sb_q.delete();
    model_ptr = 0;
    @(posedge clk);
    @(negedge clk);
    checkVal("rst_hold_out_valid", int'(ifc4.out_valid), 0);
    rst_n = 1'b1;

    // Bubble in round-robin: the idle cycle must not move the pointer.
    applyStimulus(mk(1,3,1,1, 0,0,0,1));
    checkOutput(mk(1,3,1,1, 0,0,0,1), "bub0");
    applyStimulus(mk(0,3,1,1, 0,0,0,1));
    checkOutput(mk(0,3,1,1, 0,0,0,1), "bub1");
    applyStimulus(mk(1,3,1,1, 1,0,0,1));
    checkOutput(mk(1,3,1,1, 1,0,0,1), "bub2");
    applyStimulus(mk(0,3,1,1, 0,0,0,1));
    checkOutput(mk(0,3,1,1, 0,0,0,1), "bub3");
    applyStimulus(mk(0,3,1,1, 1,3,1,1));
    checkOutput(mk(0,3,1,1, 1,3,1,1), "bub4");
    applyStimulus(mk(0,3,1,1, 0,3,1,1));
    checkOutput(mk(0,3,1,1, 0,3,1,1), "bub5");

    // Eight-channel instance: three-stage latency and both select extremes.
    step8(1, 5, 0, 8'h00, 0);
    step8(1, 0, 0, 8'h00, 0);
    step8(1, 7, 0, 8'h00, 0);
    step8(0, 0, 1, 8'h15, 5);
    step8(0, 0, 1, 8'h10, 0);
    step8(0, 0, 1, 8'h17, 7);
    step8(0, 0, 0, 8'h17, 7);

    $display("[TB] starting randomized run");
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      ifc4.in_data   = 16'($urandom);
      ifc4.sel       = 2'($urandom);
      ifc4.in_valid  = ($urandom_range(0, 3) != 0);
      ifc4.out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 15) == 0) ifc4.rr_mode = ~ifc4.rr_mode;
    end

    @(posedge clk);
    #1;
    ifc4.in_valid  = 1'b0;
    ifc4.out_ready = 1'b1;
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    checkVal("drain_queue_empty", sb_q.size(), 0);
    checkVal("drain_out_valid", int'(ifc4.out_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
